// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup and resolve paths are each one registered stage; table reads see pre-update contents.
module branch_predictor #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            F_valid,
  input  logic [XLEN-1:0] F_PC,
  output logic            Pred_valid,
  output logic [XLEN-1:0] Pred_PC,
  output logic            Pred_taken,
  output logic [XLEN-1:0] Pred_target,
  input  logic            Res_en,
  input  logic [XLEN-1:0] Res_PC,
  input  logic [XLEN-1:0] Res_target,
  input  logic            Branch_taken,
  input  logic            Res_pred_taken,
  input  logic [XLEN-1:0] Res_pred_target,
  output logic            Mispredict,
  output logic [XLEN-1:0] Redirect_PC,
  output logic [31:0]     Br_count,
  output logic [31:0]     Mispred_count
);

  localparam int ENTRIES = 1 << IDX_W;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [1:0]       tbl_ctr    [ENTRIES];
  logic [XLEN-1:0]  tbl_target [ENTRIES];

  logic [IDX_W-1:0] lk_idx_p0, up_idx_p0;
  logic [TAG_W-1:0] lk_tag_p0, up_tag_p0;
  logic             lk_taken_p0, up_hit_p0, mis_p0;
  logic [XLEN-1:0]  lk_target_p0, redirect_p0;
  logic [31:0]      br_cnt_p1, mis_cnt_p1;

  // ---- stage p0: combinational lookup and resolve evaluation
  always_comb begin
    lk_idx_p0    = F_PC[IDX_W+1:2];
    lk_tag_p0    = F_PC[IDX_W+TAG_W+1:IDX_W+2];
    lk_taken_p0  = tbl_valid[lk_idx_p0] && (tbl_tag[lk_idx_p0] == lk_tag_p0) &&
                   tbl_ctr[lk_idx_p0][1];
    lk_target_p0 = lk_taken_p0 ? tbl_target[lk_idx_p0] : F_PC + XLEN'(4);

    up_idx_p0    = Res_PC[IDX_W+1:2];
    up_tag_p0    = Res_PC[IDX_W+TAG_W+1:IDX_W+2];
    up_hit_p0    = tbl_valid[up_idx_p0] && (tbl_tag[up_idx_p0] == up_tag_p0);
    mis_p0       = Res_en && ((Branch_taken != Res_pred_taken) ||
                              (Branch_taken && (Res_pred_target != Res_target)));
    redirect_p0  = Branch_taken ? Res_target : Res_PC + XLEN'(4);
  end

  // ---- table update: control fields reset, targets are pure data
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_ctr[i]   <= 2'b01;
      end
    end else if (Res_en) begin
      if (up_hit_p0) begin
        tbl_ctr[up_idx_p0] <= Branch_taken ? ctr_inc(tbl_ctr[up_idx_p0])
                                           : ctr_dec(tbl_ctr[up_idx_p0]);
      end else if (Branch_taken) begin
        tbl_valid[up_idx_p0] <= 1'b1;
        tbl_tag[up_idx_p0]   <= up_tag_p0;
        tbl_ctr[up_idx_p0]   <= 2'b10;
      end
    end
  end

  // A taken resolve writes the target whether it hits or allocates
  always_ff @(posedge CLK) begin
    if (!rst && Res_en && Branch_taken)
      tbl_target[up_idx_p0] <= Res_target;
  end

  // ---- stage p1: registered prediction, redirect and statistics
  always_ff @(posedge CLK) begin
    if (rst) begin
      Pred_valid  <= 1'b0;
      Pred_PC     <= '0;
      Pred_taken  <= 1'b0;
      Pred_target <= '0;
      Mispredict  <= 1'b0;
      Redirect_PC <= '0;
      br_cnt_p1   <= '0;
      mis_cnt_p1  <= '0;
    end else begin
      Pred_valid  <= F_valid;
      Pred_PC     <= F_PC;
      Pred_taken  <= lk_taken_p0;
      Pred_target <= lk_target_p0;
      Mispredict  <= mis_p0;
      if (Res_en) begin
        Redirect_PC <= redirect_p0;
        br_cnt_p1   <= sat_inc32(br_cnt_p1);
      end
      if (mis_p0)
        mis_cnt_p1 <= sat_inc32(mis_cnt_p1);
    end
  end

  assign Br_count      = br_cnt_p1;
  assign Mispred_count = mis_cnt_p1;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed lookups/resolves with hand-computed expectations.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        rst;
  logic        F_valid;
  logic [31:0] F_PC;
  logic        Pred_valid;
  logic [31:0] Pred_PC;
  logic        Pred_taken;
  logic [31:0] Pred_target;
  logic        Res_en;
  logic [31:0] Res_PC;
  logic [31:0] Res_target;
  logic        Branch_taken;
  logic        Res_pred_taken;
  logic [31:0] Res_pred_target;
  logic        Mispredict;
  logic [31:0] Redirect_PC;
  logic [31:0] Br_count;
  logic [31:0] Mispred_count;

  branch_predictor #(.XLEN(32), .IDX_W(6), .TAG_W(8)) dut (
    .CLK(CLK), .rst(rst),
    .F_valid(F_valid), .F_PC(F_PC),
    .Pred_valid(Pred_valid), .Pred_PC(Pred_PC), .Pred_taken(Pred_taken), .Pred_target(Pred_target),
    .Res_en(Res_en), .Res_PC(Res_PC), .Res_target(Res_target), .Branch_taken(Branch_taken),
    .Res_pred_taken(Res_pred_taken), .Res_pred_target(Res_pred_target),
    .Mispredict(Mispredict), .Redirect_PC(Redirect_PC),
    .Br_count(Br_count), .Mispred_count(Mispred_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] pc; logic taken; logic [31:0] target; } pred_t;
  typedef struct packed { logic mis; logic [31:0] redir; } res_t;

  pred_t pred_q[$];
  res_t  res_q[$];
  pred_t pe;
  res_t  re;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  logic  res_pending = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    F_valid = 1'b1;
    F_PC    = pc;
    if (!rst) pred_q.push_back({pc, t, tgt});
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic bt,
                         input logic pt, input logic [31:0] ptgt,
                         input logic mis, input logic [31:0] redir);
    Res_en          = 1'b1;
    Res_PC          = pc;
    Res_target      = tgt;
    Branch_taken    = bt;
    Res_pred_taken  = pt;
    Res_pred_target = ptgt;
    if (!rst) res_q.push_back({mis, redir});
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    F_valid = 1'b0;
    Res_en  = 1'b0;
  endtask

  task automatic check_counts(input string tag, input logic [31:0] br, input logic [31:0] mis);
    check32({tag, "_br_count"}, Br_count, br);
    check32({tag, "_mispred_count"}, Mispred_count, mis);
  endtask

  // Monitor: a resolve issued before an edge owes a Mispredict verdict right after it
  always @(posedge CLK) res_pending <= Res_en && !rst;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (Pred_valid) begin
        if (pred_q.size() == 0) begin
          check32("pred_valid_unexpected", {31'b0, Pred_valid}, 32'd0);
        end else begin
          pe = pred_q.pop_front();
          check32("pred_pc", Pred_PC, pe.pc);
          check32("pred_taken", {31'b0, Pred_taken}, {31'b0, pe.taken});
          check32("pred_target", Pred_target, pe.target);
        end
      end
      if (res_pending && res_q.size() != 0) begin
        re = res_q.pop_front();
        check32("mispredict", {31'b0, Mispredict}, {31'b0, re.mis});
        if (re.mis) check32("redirect_pc", Redirect_PC, re.redir);
      end else begin
        check32("mispredict_idle", {31'b0, Mispredict}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; F_valid = 1'b0; F_PC = '0; Res_en = 1'b0; Res_PC = '0; Res_target = '0;
    Branch_taken = 1'b0; Res_pred_taken = 1'b0; Res_pred_target = '0;
    lookup(32'h100, 1'b0, 32'h104);
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    check32("rst_pred_valid", {31'b0, Pred_valid}, 32'd0);
    check32("rst_pred_target", Pred_target, 32'd0);
    check32("rst_redirect_pc", Redirect_PC, 32'd0);
    check32("rst_mispredict", {31'b0, Mispredict}, 32'd0);
    check_counts("rst", 32'd0, 32'd0);

    // Cold lookup misses
    lookup(32'h100, 1'b0, 32'h104); tick();
    // Allocate 0x100 -> 0x80 (predicted not taken: mispredict)
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h104, 1'b1, 32'h80); tick();
    lookup(32'h100, 1'b1, 32'h80); tick();
    check_counts("alloc", 32'd1, 32'd1);

    // Saturate at 3, then hysteresis on not-taken
    resolve(32'h100, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0); tick();
    resolve(32'h100, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0); tick();
    resolve(32'h100, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 32'h104); tick();
    lookup(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 32'h104); tick();
    lookup(32'h100, 1'b0, 32'h104);
    resolve(32'h100, 32'h80, 1'b0, 1'b0, 32'h104, 1'b0, 32'h0); tick();
    check_counts("hyst", 32'd6, 32'd3);

    // Alias at same index, different tag, replaces the entry
    resolve(32'h200, 32'h200, 1'b1, 1'b0, 32'h204, 1'b1, 32'h200); tick();
    lookup(32'h100, 1'b0, 32'h104); tick();
    lookup(32'h200, 1'b1, 32'h200); tick();
    check_counts("alias", 32'd7, 32'd4);

    // Right direction, wrong target
    resolve(32'h200, 32'h84, 1'b1, 1'b1, 32'h80, 1'b1, 32'h84); tick();
    lookup(32'h200, 1'b1, 32'h84); tick();

    // Not-taken misses never allocate
    resolve(32'h400, 32'h999, 1'b0, 1'b0, 32'h404, 1'b0, 32'h0); tick();
    lookup(32'h200, 1'b1, 32'h84);
    resolve(32'h404, 32'h777, 1'b0, 1'b1, 32'h777, 1'b1, 32'h408); tick();
    check_counts("nt_miss", 32'd10, 32'd6);

    // Wrap-around of PC+4 on both paths
    lookup(32'hFFFF_FFFC, 1'b0, 32'h0);
    resolve(32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0); tick();

    // Same-cycle lookup and allocate: read-before-write
    lookup(32'h104, 1'b0, 32'h108);
    resolve(32'h104, 32'h500, 1'b1, 1'b0, 32'h108, 1'b1, 32'h500); tick();
    lookup(32'h104, 1'b1, 32'h500); tick();
    check_counts("rbw", 32'd12, 32'd8);

    // Reset overrides a mispredicting resolve and a lookup
    rst = 1'b1;
    resolve(32'h104, 32'h600, 1'b1, 1'b0, 32'h108, 1'b1, 32'h600);
    lookup(32'h104, 1'b0, 32'h108);
    tick();
    rst = 1'b0;
    check32("rst2_pred_valid", {31'b0, Pred_valid}, 32'd0);
    check32("rst2_mispredict", {31'b0, Mispredict}, 32'd0);
    check_counts("rst2", 32'd0, 32'd0);
    lookup(32'h104, 1'b0, 32'h108); tick();
    lookup(32'h200, 1'b0, 32'h204); tick();

    // Counter saturation from a preloaded near-max value
    force dut.br_cnt_p1 = 32'hFFFF_FFFE;
    force dut.mis_cnt_p1 = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt_p1;
    release dut.mis_cnt_p1;
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h104, 1'b1, 32'h80); tick();
    check_counts("sat1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h104, 1'b1, 32'h80); tick();
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h104, 1'b1, 32'h80); tick();
    check_counts("sat2", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    tick();
    tick();
    check32("pred_q_drained", pred_q.size(), 32'd0);
    check32("res_q_drained", res_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
